// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if
//   Groups the instruction-in and immediate-out handshakes of imm_gen_pipe.
//   slave  : the decoder side. It takes instructions in and drives results out.
//   master : the producer/consumer side (testbench or surrounding pipeline).
// Signals
//   in_valid / in_ready / in_instr[31:0]       : instruction transfer
//   out_valid / out_ready                      : result transfer
//   out_imm[XLEN-1:0], out_fmt[2:0], out_illegal : decoded result
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   RISC-V immediate generator with a two-entry skid buffer on its output.
//   Each accepted instruction is decoded combinationally at the input and the
//   result (sign-extended immediate, format code, illegal flag) is captured in
//   the buffer. All outputs come straight from registers.
// Parameters
//   XLEN     : immediate width, 32 or 64
//   FULL_ISA : 1 decodes I/S/B/U/J; 0 decodes I/S/U only and flags B/J illegal
//   CNT_W    : width of the saturating illegal-instruction counter
// Ports
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   bus         : imm_gen_pipe_if.slave (instruction in, result out)
//   illegal_cnt : saturating count of accepted illegal instructions
module imm_gen_pipe #(
  parameter int XLEN     = 32,
  parameter bit FULL_ISA = 1'b1,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  imm_gen_pipe_if.slave     bus,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  // Every format is first assembled as a 32-bit signed value whose bit 31
  // already carries the sign; widening to XLEN is then a plain sign extension.
  // This also gives the U-format its bit-31 extension on 64-bit builds.
  function automatic logic signed [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = signed'(v);
    return XLEN'(s);
  endfunction

  function automatic entry_t decode(input logic [31:0] instr);
    entry_t      e;
    logic [31:0] raw;
    e   = '0;
    raw = '0;
    case (instr[6:0])
      OP_LOAD, OP_IMM, OP_JALR: begin
        raw   = {{20{instr[31]}}, instr[31:20]};
        e.fmt = FMT_I;
      end
      OP_STORE: begin
        raw   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        e.fmt = FMT_S;
      end
      OP_BRANCH: begin
        if (FULL_ISA) begin
          raw   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                   instr[11:8], 1'b0};
          e.fmt = FMT_B;
        end else begin
          e.ill = 1'b1;
        end
      end
      OP_LUI, OP_AUIPC: begin
        raw   = {instr[31:12], 12'b0};
        e.fmt = FMT_U;
      end
      OP_JAL: begin
        if (FULL_ISA) begin
          raw   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                   instr[30:21], 1'b0};
          e.fmt = FMT_J;
        end else begin
          e.ill = 1'b1;
        end
      end
      default: e.ill = 1'b1;
    endcase
    // Illegal opcodes leave raw at zero, so the immediate reads back as 0.
    e.imm = sext32(raw);
    return e;
  endfunction

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  entry_t           main_q;
  entry_t           skid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  entry_t dec;
  logic   acc;
  logic   drn;

  // Input stage: decode happens before the buffer so stored entries are final
  assign dec = decode(bus.in_instr);
  assign acc = bus.in_valid & in_ready_q;
  assign drn = out_valid_q & bus.out_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (acc && dec.ill && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Buffer stage: main holds the entry being presented, skid absorbs the one
  // that arrives while the consumer stalls. in_ready is a register so the
  // producer never sees a combinational path from out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
      cnt_q       <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        S_EMPTY: begin
          if (acc) begin
            main_q      <= dec;
            out_valid_q <= 1'b1;
            state_q     <= S_ONE;
          end
        end
        S_ONE: begin
          if (acc && drn) begin
            main_q <= dec;
          end else if (acc) begin
            skid_q     <= dec;
            in_ready_q <= 1'b0;
            state_q    <= S_FULL;
          end else if (drn) begin
            out_valid_q <= 1'b0;
            state_q     <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (drn) begin
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= S_ONE;
          end
        end
        default: begin
          state_q     <= S_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_fmt     = main_q.fmt;
  assign bus.out_illegal = main_q.ill;
  assign illegal_cnt     = cnt_q;

endmodule
